mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between instruction fetch (driven from pc) and the s2 load/store stage.
- Owns the port state machine and the registered request/response handshakes.
- Data accesses have priority, with a bounded-starvation rule for fetch.
- Exports the busy status that the control unit's mem-in-use stall logic consumes.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced ahead (0 = data always wins, counter disabled)
CNT_W, 3, width of starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clk_enable  input  1  global advance enable; all registers hold when low (memory shares this enable)
fetch_req  input  1  fetch request level, held until fetch_valid or fetch_flush
fetch_addr  input  30  fetch word address
fetch_flush  input  1  branch flush: cancel pending/outstanding fetch
fetch_grant  output  1  one-cycle pulse: fetch request captured
fetch_valid  output  1  one-cycle pulse: fetch_data valid
fetch_data  output  32  instruction word
data_req  input  1  data request level, held until data_valid
data_we  input  1  1 = store
data_addr  input  30  data word address
data_wdata  input  32  store data
data_wmask  input  4  store byte enables
data_grant  output  1  one-cycle pulse: data request captured
data_valid  output  1  one-cycle pulse: load data valid / store complete
data_rdata  output  32  load data (0 for stores)
port_busy  output  1  high whenever state != IDLE
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write
mem_addr  output  30  memory word address
mem_wdata  output  32  memory write data
mem_wmask  output  4  memory byte enables (0000 for reads)
mem_ack  input  1  one-cycle completion; mem_rdata valid same cycle
mem_rdata  input  32  memory read data

Behaviour:
- Reset: asynchronous on rst_n low. State IDLE, starve_cnt 0, flush_pending 0, every output 0. A reset mid-transaction drops mem_req immediately; memory abandons the access.
- clk_enable low: no register changes; mem_ack is ignored (memory is frozen by the same enable).
- States: IDLE, FETCH, DATA. All outputs are registered.
- IDLE arbitration, evaluated on each enabled edge:
  - data only -> DATA.
  - fetch only -> FETCH.
  - both -> FETCH if STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, else DATA.
  - fetch_req with fetch_flush asserted in the same cycle is not a request.
- On entering FETCH/DATA: mem_req = 1, and mem_addr/we/wdata/wmask latch the winner's inputs. The matching *_grant pulses in that same cycle.
- mem_req and the mem_* fields stay stable until mem_ack is sampled. On mem_ack, next state is IDLE and mem_req drops.
  - No new request issues in the ack cycle itself: back-to-back accesses are separated by one IDLE cycle.
- Response: on the edge sampling mem_ack, the owner's *_valid pulses for one cycle and *_data/rdata register mem_rdata (data_rdata = 0 when data_we). Minimum latency: request at edge t -> grant/mem_req after t -> ack sampled at t+1 -> valid after t+1.
- Flush:
  - fetch_flush in FETCH sets flush_pending. The memory access still completes, fetch_valid is suppressed, and flush_pending clears on ack.
  - fetch_flush in the same cycle as mem_ack also suppresses fetch_valid.
  - fetch_flush has no effect on DATA.
- Starvation counter, updated only at IDLE arbitration:
  - data granted while fetch_req is high -> starve_cnt + 1, saturating at STARVE_LIMIT.
  - fetch granted, or fetch_req low -> starve_cnt = 0.
- port_busy is registered: 1 in FETCH/DATA, 0 in IDLE.
- Requesters must hold req and its fields stable until their valid pulse. Changing the fields after grant has no effect on the current access, because the fields were latched.

Test Plan:
- Single fetch, fetch_addr=0x0000100, ack after 3 cycles with mem_rdata=0x00500093 -> fetch_grant pulses; mem_req is held for 3 cycles with mem_wmask=0000; fetch_valid pulses once with fetch_data=0x00500093; port_busy returns to 0.
- Simultaneous fetch and store (data_addr=0x10, wdata=0xDEADBEEF, wmask=1111), zero-wait ack -> data served first and data_rdata=0. One IDLE cycle follows, then fetch is issued.
- STARVE_LIMIT=4, data_req and fetch_req held continuously -> exactly 4 data grants, then a fetch grant, then starve_cnt returns to 0 and the pattern repeats.
- fetch_flush pulsed 1 cycle after fetch_grant, ack 2 cycles later -> the memory access completes, fetch_valid stays 0, and the next fetch_req is granted normally.
- rst_n pulled low mid-DATA with clk_enable=1 -> mem_req, port_busy and all valids go to 0 immediately without a clock edge; after release, state is IDLE and starve_cnt=0.
- clk_enable=0 for 5 cycles while mem_ack=1 in FETCH -> no state change and no fetch_valid. The first enabled edge with mem_ack=1 produces fetch_valid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single shared memory port: instruction fetch vs. s2 load/store.
// Data wins by default; fetch is forced ahead after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              fetch_req,
  input  logic [29:0]       fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_grant,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [29:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wmask,
  output logic              data_grant,
  output logic              data_valid,
  output logic [31:0]       data_rdata,
  output logic              port_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [29:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Handshake: *_req is a level held by the requester until its *_valid pulse;
  // *_grant pulses when the request is latched onto the port; mem_req is held
  // with stable fields until mem_ack is sampled on an enabled edge.

  state_t           state_q;
  logic [CNT_W-1:0] starve_cnt_q;
  logic             flush_pending_q;
  logic             fetch_grant_q, fetch_valid_q, data_grant_q, data_valid_q;
  logic [31:0]      fetch_data_q, data_rdata_q;
  logic             port_busy_q, mem_req_q, mem_we_q;
  logic [29:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wmask_q;

  logic fetch_live;
  logic force_fetch;

  // A fetch request raised together with a flush is already cancelled.
  assign fetch_live  = fetch_req & ~fetch_flush;
  assign force_fetch = (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      starve_cnt_q    <= '0;
      flush_pending_q <= 1'b0;
      fetch_grant_q   <= 1'b0;
      fetch_valid_q   <= 1'b0;
      fetch_data_q    <= '0;
      data_grant_q    <= 1'b0;
      data_valid_q    <= 1'b0;
      data_rdata_q    <= '0;
      port_busy_q     <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
    end else if (clk_enable) begin
      fetch_grant_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      data_grant_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (data_req && !(fetch_live && force_fetch)) begin
            state_q      <= ST_DATA;
            data_grant_q <= 1'b1;
            port_busy_q  <= 1'b1;
            mem_req_q    <= 1'b1;
            mem_we_q     <= data_we;
            mem_addr_q   <= data_addr;
            mem_wdata_q  <= data_wdata;
            mem_wmask_q  <= data_we ? data_wmask : 4'b0000;
            if (!fetch_live)
              starve_cnt_q <= '0;
            else if (starve_cnt_q != STARVE_MAX)
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
          end else if (fetch_live) begin
            state_q         <= ST_FETCH;
            fetch_grant_q   <= 1'b1;
            port_busy_q     <= 1'b1;
            mem_req_q       <= 1'b1;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= fetch_addr;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= 4'b0000;
            starve_cnt_q    <= '0;
            flush_pending_q <= 1'b0;
          end else begin
            starve_cnt_q <= '0;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            state_q         <= ST_IDLE;
            port_busy_q     <= 1'b0;
            mem_req_q       <= 1'b0;
            fetch_valid_q   <= ~(flush_pending_q | fetch_flush);
            fetch_data_q    <= mem_rdata;
            flush_pending_q <= 1'b0;
          end else if (fetch_flush) begin
            flush_pending_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (mem_ack) begin
            state_q      <= ST_IDLE;
            port_busy_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            data_valid_q <= 1'b1;
            data_rdata_q <= mem_we_q ? 32'h0 : mem_rdata;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          port_busy_q <= 1'b0;
          mem_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_grant    = fetch_grant_q;
  assign fetch_valid    = fetch_valid_q;
  assign fetch_data     = fetch_data_q;
  assign data_grant     = data_grant_q;
  assign data_valid     = data_valid_q;
  assign data_rdata     = data_rdata_q;
  assign port_busy      = port_busy_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule
